counter_ctrl_3bit: RTL and testbench

Sequencing controller for the 3-bit counter datapath. It owns the state register Q and selects the adder operand b: +1, -1 (encoded 3'b111), a programmable step, or 0. Start/stop FSM, synchronous load, wrap detection with a terminal-count pulse, and a one-shot mode that halts at the first wrap. It sits between the board-level control inputs and the counter display/output logic.

---
 rtl/counter_pkg.sv | 17 +
 rtl/adder_3bit.sv | 13 +
 rtl/counter_ctrl_3bit.sv | 161 ++++++++++++++++
 tb/tb_counter_ctrl_3bit.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared encodings for the 3-bit counter controller: modes, FSM states, width.
package counter_pkg;

  localparam int unsigned CNT_W = 3;

  localparam logic [1:0] MODE_UP   = 2'b00;
  localparam logic [1:0] MODE_DOWN = 2'b01;
  localparam logic [1:0] MODE_STEP = 2'b10;
  localparam logic [1:0] MODE_HOLD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/adder_3bit.sv
// Modulo-8 adder used by the counter datapath; carry out exposed for completeness.
module adder_3bit
  import counter_pkg::*;
(
  input  logic [CNT_W-1:0] a,
  input  logic [CNT_W-1:0] b,
  output logic [CNT_W-1:0] sum,
  output logic             carry
);

  assign {carry, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/counter_ctrl_3bit.sv
// Sequencing controller for the 3-bit counter: operand select, wrap detect, start/stop FSM.
// Optional COUNTER_CTRL_SAT_EN replaces non-oneshot wraps with saturation at 0 / 7.
module counter_ctrl_3bit
  import counter_pkg::*;
#(
  parameter logic [CNT_W-1:0] RESET_VAL    = 3'd0,
  parameter logic [CNT_W-1:0] DEFAULT_STEP = 3'd2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic [1:0]       mode_i,
  input  logic [CNT_W-1:0] step_i,
  input  logic             oneshot_i,
  output logic [CNT_W-1:0] q_o,
  output logic             busy_o,
  output logic             tc_o,
  output logic             done_o
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] q_q, q_d;
  logic             tc_q, tc_d;
  logic [CNT_W-1:0] b_op;
  logic [CNT_W-1:0] next_q;
  logic             unused_carry;
  logic             wrap;

`ifdef COUNTER_CTRL_SAT_EN
  // Remember which rail we are clamped against so tc fires only on entry.
  logic sat_hi_q, sat_hi_d;
  logic sat_lo_q, sat_lo_d;
`endif

  always_comb begin
    b_op = '0;
    unique case (mode_i)
      MODE_UP:   b_op = 3'b001;
      MODE_DOWN: b_op = 3'b111;
      MODE_STEP: b_op = (step_i != '0) ? step_i : DEFAULT_STEP;
      default:   b_op = '0;
    endcase
  end

  adder_3bit u_adder (
    .a     (q_q),
    .b     (b_op),
    .sum   (next_q),
    .carry (unused_carry)
  );

  always_comb begin
    wrap = 1'b0;
    unique case (mode_i)
      MODE_UP, MODE_STEP: wrap = (next_q < q_q);
      MODE_DOWN:          wrap = (q_q == '0);
      default:            wrap = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    tc_d    = 1'b0;
`ifdef COUNTER_CTRL_SAT_EN
    sat_hi_d = sat_hi_q;
    sat_lo_d = sat_lo_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (load_i) begin
          q_d = load_val_i;
        end else if (start_i && !stop_i) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (load_i) begin
          q_d = load_val_i;
        end else if (stop_i) begin
          state_d = ST_IDLE;
        end else if (wrap && oneshot_i) begin
          tc_d    = 1'b1;
          state_d = ST_DONE;
        end else if (wrap) begin
`ifdef COUNTER_CTRL_SAT_EN
          if (mode_i == MODE_DOWN) begin
            q_d      = '0;
            tc_d     = !sat_lo_q;
            sat_lo_d = 1'b1;
          end else begin
            q_d      = '1;
            tc_d     = !sat_hi_q;
            sat_hi_d = 1'b1;
          end
`else
          q_d  = next_q;
          tc_d = 1'b1;
`endif
        end else begin
          q_d = next_q;
`ifdef COUNTER_CTRL_SAT_EN
          if (mode_i == MODE_DOWN) begin
            sat_hi_d = 1'b0;
          end else if (mode_i != MODE_HOLD) begin
            sat_lo_d = 1'b0;
          end
`endif
        end
      end
      ST_DONE: begin
        if (load_i) begin
          q_d     = load_val_i;
          state_d = ST_IDLE;
        end else if (start_i) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
`ifdef COUNTER_CTRL_SAT_EN
    if (load_i) begin
      sat_hi_d = 1'b0;
      sat_lo_d = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      q_q     <= RESET_VAL;
      tc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      tc_q    <= tc_d;
    end
  end

`ifdef COUNTER_CTRL_SAT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_hi_q <= 1'b0;
      sat_lo_q <= 1'b0;
    end else begin
      sat_hi_q <= sat_hi_d;
      sat_lo_q <= sat_lo_d;
    end
  end
`endif

  assign q_o    = q_q;
  assign busy_o = (state_q == ST_RUN);
  assign done_o = (state_q == ST_DONE);
  assign tc_o   = tc_q;

endmodule

// File: tb/tb_counter_ctrl_3bit.sv
// Scoreboard bench for counter_ctrl_3bit: stimulus queues expected outputs, monitor compares.
module tb_counter_ctrl_3bit;
  import counter_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_i = 1'b0, stop_i = 1'b0, load_i = 1'b0, oneshot_i = 1'b0;
  logic [2:0] load_val_i = 3'd0, step_i = 3'd0;
  logic [1:0] mode_i = MODE_UP;
  logic [2:0] q_o;
  logic       busy_o, tc_o, done_o;

  typedef struct {
    logic [2:0] q;
    logic       busy;
    logic       tc;
    logic       done;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  event ev_now;

  always #5 clk = ~clk;

  counter_ctrl_3bit #(
    .RESET_VAL    (3'd0),
    .DEFAULT_STEP (3'd2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (start_i),
    .stop_i     (stop_i),
    .load_i     (load_i),
    .load_val_i (load_val_i),
    .mode_i     (mode_i),
    .step_i     (step_i),
    .oneshot_i  (oneshot_i),
    .q_o        (q_o),
    .busy_o     (busy_o),
    .tc_o       (tc_o),
    .done_o     (done_o)
  );

  // Monitor: one sample per rising edge (or on demand for async events), 1ns after.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk or ev_now);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (q_o !== e.q || busy_o !== e.busy || tc_o !== e.tc || done_o !== e.done) begin
          errors++;
          $display("FAIL %s: got q=%0d busy=%0b tc=%0b done=%0b, expected q=%0d busy=%0b tc=%0b done=%0b",
                   e.name, q_o, busy_o, tc_o, done_o, e.q, e.busy, e.tc, e.done);
        end
      end
    end
  end

  task automatic push_exp(input logic [2:0] q, input logic b, input logic t, input logic d,
                          input string nm);
    exp_t e;
    e.q = q; e.busy = b; e.tc = t; e.done = d; e.name = nm;
    sb.push_back(e);
  endtask

  // Inputs are set by the caller at a falling edge; expectation is for after the next rise.
  task automatic tick(input logic [2:0] q, input logic b, input logic t, input logic d,
                      input string nm);
    push_exp(q, b, t, d, nm);
    @(negedge clk);
    start_i = 1'b0;
    stop_i  = 1'b0;
    load_i  = 1'b0;
  endtask

  task automatic chk_now(input logic [2:0] q, input logic b, input logic t, input logic d,
                         input string nm);
    push_exp(q, b, t, d, nm);
    -> ev_now;
  endtask

  initial begin
    #1 chk_now(3'd0, 0, 0, 0, "reset");
    @(negedge clk);
    rst_n = 1'b1;
    tick(3'd0, 0, 0, 0, "idle_hold");
    start_i = 1'b1;
    tick(3'd0, 1, 0, 0, "start_latency");
`ifndef COUNTER_CTRL_SAT_EN
    for (int i = 1; i <= 7; i++) tick(3'(i), 1, 0, 0, "up_count");
    tick(3'd0, 1, 1, 0, "up_wrap_tc");
    tick(3'd1, 1, 0, 0, "up_after_wrap");
    load_i = 1'b1; load_val_i = 3'd2; mode_i = MODE_DOWN; oneshot_i = 1'b1;
    tick(3'd2, 1, 0, 0, "load_in_run");
    tick(3'd1, 1, 0, 0, "down_1");
    tick(3'd0, 1, 0, 0, "down_0");
    tick(3'd0, 0, 1, 1, "oneshot_down_done");
    tick(3'd0, 0, 0, 1, "done_hold");
    oneshot_i = 1'b0; start_i = 1'b1;
    tick(3'd0, 1, 0, 0, "done_resume");
    tick(3'd7, 1, 1, 0, "down_wrap");
    tick(3'd6, 1, 0, 0, "down_6");
    load_i = 1'b1; load_val_i = 3'd6; mode_i = MODE_STEP; step_i = 3'd3;
    tick(3'd6, 1, 0, 0, "load_6");
    tick(3'd1, 1, 1, 0, "step3_wrap");
    tick(3'd4, 1, 0, 0, "step3_4");
    tick(3'd7, 1, 0, 0, "step3_7");
    tick(3'd2, 1, 1, 0, "step3_wrap2");
    step_i = 3'd0;
    tick(3'd4, 1, 0, 0, "step_default_4");
    tick(3'd6, 1, 0, 0, "step_default_6");
    tick(3'd0, 1, 1, 0, "step_default_wrap");
`else
    load_i = 1'b1; load_val_i = 3'd5; mode_i = MODE_UP;
    tick(3'd5, 1, 0, 0, "sat_load_5");
    tick(3'd6, 1, 0, 0, "sat_6");
    tick(3'd7, 1, 0, 0, "sat_7");
    tick(3'd7, 1, 1, 0, "sat_clamp_tc");
    tick(3'd7, 1, 0, 0, "sat_hold");
    mode_i = MODE_DOWN;
    tick(3'd6, 1, 0, 0, "sat_release");
`endif
    load_i = 1'b1; stop_i = 1'b1; load_val_i = 3'd5;
    tick(3'd5, 1, 0, 0, "load_beats_stop");
    stop_i = 1'b1;
    tick(3'd5, 0, 0, 0, "stop_to_idle");
    start_i = 1'b1; stop_i = 1'b1;
    tick(3'd5, 0, 0, 0, "stop_beats_start");
    start_i = 1'b1; mode_i = MODE_HOLD;
    tick(3'd5, 1, 0, 0, "start_hold");
    start_i = 1'b1;
    tick(3'd5, 1, 0, 0, "start_in_run_ignored");
    load_i = 1'b1; load_val_i = 3'd6; mode_i = MODE_UP; oneshot_i = 1'b1;
    tick(3'd6, 1, 0, 0, "load_6_up");
    tick(3'd7, 1, 0, 0, "up_7");
    tick(3'd7, 0, 1, 1, "oneshot_up_done");
    load_i = 1'b1; load_val_i = 3'd3;
    tick(3'd3, 0, 0, 0, "load_in_done_idle");
    start_i = 1'b1; oneshot_i = 1'b0;
    tick(3'd3, 1, 0, 0, "restart");
    tick(3'd4, 1, 0, 0, "pre_reset");
    rst_n = 1'b0;
    chk_now(3'd0, 0, 0, 0, "async_reset_mid_run");
    #2 rst_n = 1'b1;
    tick(3'd0, 0, 0, 0, "post_reset_idle");
    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: got timeout at %0t, expected completion", $time);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
